// File: rtl/cpu_irq_ctrl_pkg.sv
// Shared MIPS decode constants and IRQ controller register map.
// The control decoder imports the same legal-instruction lists.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_BLEZ = 6'h06;
    localparam logic [5:0] OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_LUI = 6'h0f;
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;

    // Word index within the peripheral window (addr[3:2]).
    localparam logic [1:0] REG_TH = 2'd0;
    localparam logic [1:0] REG_TL = 2'd1;
    localparam logic [1:0] REG_TCON = 2'd2;
    localparam logic [1:0] REG_CAUSE = 2'd3;

    localparam int TCON_EN = 0;
    localparam int TCON_IEN = 1;
    localparam int TCON_STATUS = 2;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_REGIMM, OP_J, OP_JAL,
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_LUI, OP_LW, OP_SW:
                op_legal = 1'b1;
            default:
                op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic fn_legal(input logic [5:0] fn);
        case (fn)
            FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_JALR,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT:
                fn_legal = 1'b1;
            default:
                fn_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_undef(
        input logic [5:0] op,
        input logic [5:0] fn
    );
        is_undef = !op_legal(op)
                 || ((op == OP_RTYPE) && !fn_legal(fn));
    endfunction

endpackage

// File: rtl/cpu_irq_ctrl_if.sv
// Data-memory bus between the datapath (master) and
// the IRQ peripheral (slave).
interface cpu_irq_ctrl_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_wr,
        output mem_rd,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_wr,
        input  mem_rd,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_irq_ctrl_timer.sv
// Memory-mapped reload timer: TH, TL and TCON registers,
// bus write decode and overflow detection.
module irq_timer
    import mips_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [31:0] TH_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic        en,
    output logic        ien,
    output logic        status
);

    logic sel;
    logic wr_th;
    logic wr_tl;
    logic wr_tcon;
    logic ovf;
    logic overflow_set;

    assign sel = (addr[31:4] == BASE_ADDR[31:4])
              && (addr[1:0] == 2'b00);
    assign wr_th = wr && sel && (addr[3:2] == REG_TH);
    assign wr_tl = wr && sel && (addr[3:2] == REG_TL);
    assign wr_tcon = wr && sel && (addr[3:2] == REG_TCON);

    assign ovf = en && (tl == 32'hFFFF_FFFF);
    assign overflow_set = ovf && ien;

    always_ff @(posedge clk) begin
        if (reset) begin
            th <= TH_RESET;
            tl <= 32'h0;
            en <= 1'b0;
            ien <= 1'b0;
            status <= 1'b0;
        end else begin
            if (wr_th)
                th <= wdata;
            // Bus write wins; reload reads the pre-edge TH.
            if (wr_tl)
                tl <= wdata;
            else if (en)
                tl <= ovf ? th : tl + 32'd1;
            if (wr_tcon) begin
                en <= wdata[TCON_EN];
                ien <= wdata[TCON_IEN];
                status <= wdata[TCON_STATUS] | overflow_set;
            end else if (overflow_set) begin
                status <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_irq_ctrl.sv
// Interrupt/exception source: timer peripheral, undefined
// instruction decode, supervisor masking, CAUSE and ack.
module cpu_irq_ctrl
    import mips_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [31:0] TH_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            pchigh,
    cpu_irq_ctrl_if.slave   bus,
    output logic            Interrupt,
    output logic            Exception,
    output logic            irq_ack
);

    logic [31:0] th;
    logic [31:0] tl;
    logic        en;
    logic        ien;
    logic        status;
    logic [31:0] cause;
    logic        undef;
    logic        sel;
    logic        take;

    irq_timer #(
        .BASE_ADDR (BASE_ADDR),
        .TH_RESET  (TH_RESET)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .addr   (bus.mem_addr),
        .wdata  (bus.mem_wdata),
        .wr     (bus.mem_wr),
        .th     (th),
        .tl     (tl),
        .en     (en),
        .ien    (ien),
        .status (status)
    );

    assign undef = is_undef(opcode, funct);

    // Nothing is raised while reset is held.
    assign Interrupt = status && ien && !pchigh && !reset;
    assign Exception = undef && !pchigh && !Interrupt && !reset;
    assign take = Interrupt || Exception;

    assign sel = (bus.mem_addr[31:4] == BASE_ADDR[31:4])
              && (bus.mem_addr[1:0] == 2'b00);

    always_comb begin
        bus.mem_rdata = 32'h0;
        if (bus.mem_rd && sel) begin
            case (bus.mem_addr[3:2])
                REG_TH:   bus.mem_rdata = th;
                REG_TL:   bus.mem_rdata = tl;
                REG_TCON: bus.mem_rdata = {29'b0, status, ien, en};
                default:  bus.mem_rdata = cause;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cause <= 32'h0;
            irq_ack <= 1'b0;
        end else begin
            irq_ack <= take;
            if (take)
                cause <= {30'b0, Exception, Interrupt};
        end
    end

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Directed bench for cpu_irq_ctrl: timer, masking,
// undefined-instruction exception, CAUSE and reset.
module tb_cpu_irq_ctrl;

    localparam logic [31:0] A_TH = 32'h4000_0000;
    localparam logic [31:0] A_TL = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_CAUSE = 32'h4000_000C;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       pchigh = 1'b0;
    logic       Interrupt;
    logic       Exception;
    logic       irq_ack;

    int errors = 0;
    int checks = 0;

    cpu_irq_ctrl_if bus();

    cpu_irq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .pchigh    (pchigh),
        .bus       (bus),
        .Interrupt (Interrupt),
        .Exception (Exception),
        .irq_ack   (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.mem_addr = a;
        bus.mem_wdata = d;
        bus.mem_wr = 1'b1;
        tick();
        bus.mem_wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.mem_addr = a;
        bus.mem_rd = 1'b1;
        #1;
        v = bus.mem_rdata;
        bus.mem_rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] addrs [4];
        addrs = '{A_TH, A_TL, A_TCON, A_CAUSE};
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        checks++;
        if (Interrupt !== 1'b0 || Exception !== 1'b0 || irq_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: got I=%b E=%b ack=%b required 0 0 0",
                     Interrupt, Exception, irq_ack);
        end
        for (int i = 0; i < 4; i++) begin
            rd(addrs[i], v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %h required 0", i, v);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        wr(A_TH, 32'hFFFF_FFF0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        tick();
        tick();
        rd(A_TL, v);
        checks++;
        if (v !== 32'hFFFF_FFF0) begin
            errors++;
            $display("FAIL ovf_reload: got %h required fffffff0", v);
        end
        rd(A_TCON, v);
        checks++;
        if (v !== 32'h7) begin
            errors++;
            $display("FAIL ovf_status: got %h required 7", v);
        end
        checks++;
        if (Interrupt !== 1'b1 || Exception !== 1'b0) begin
            errors++;
            $display("FAIL ovf_irq: got I=%b E=%b required 1 0",
                     Interrupt, Exception);
        end
        pchigh = 1'b1;
        #1;
        checks++;
        if (Interrupt !== 1'b0) begin
            errors++;
            $display("FAIL ovf_mask: got I=%b required 0", Interrupt);
        end
        wr(A_TCON, 32'h0);
        pchigh = 1'b0;
        #1;
        checks++;
        if (Interrupt !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got I=%b required 0", Interrupt);
        end
    endtask

    task automatic test_tcon_collision();
        logic [31:0] v;
        pchigh = 1'b1;
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        tick();
        wr(A_TCON, 32'h3);
        rd(A_TCON, v);
        checks++;
        if (v !== 32'h7) begin
            errors++;
            $display("FAIL tcon_collide: got %h required 7", v);
        end
        rd(A_TL, v);
        checks++;
        if (v !== 32'hFFFF_FFF0) begin
            errors++;
            $display("FAIL tcon_collide_tl: got %h required fffffff0", v);
        end
        wr(A_TCON, 32'h0);
        pchigh = 1'b0;
    endtask

    task automatic test_exception();
        logic [31:0] v;
        tick();
        opcode = 6'h3f;
        #1;
        checks++;
        if (Exception !== 1'b1 || Interrupt !== 1'b0) begin
            errors++;
            $display("FAIL exc_op: got E=%b I=%b required 1 0",
                     Exception, Interrupt);
        end
        tick();
        opcode = 6'h00;
        funct = 6'h20;
        rd(A_CAUSE, v);
        checks++;
        if (v !== 32'h2 || irq_ack !== 1'b1) begin
            errors++;
            $display("FAIL exc_cause: got cause=%h ack=%b required 2 1",
                     v, irq_ack);
        end
        tick();
        checks++;
        if (irq_ack !== 1'b0) begin
            errors++;
            $display("FAIL exc_ack_pulse: got ack=%b required 0", irq_ack);
        end
        funct = 6'h01;
        #1;
        checks++;
        if (Exception !== 1'b1) begin
            errors++;
            $display("FAIL exc_funct: got E=%b required 1", Exception);
        end
        pchigh = 1'b1;
        #1;
        checks++;
        if (Exception !== 1'b0) begin
            errors++;
            $display("FAIL exc_super: got E=%b required 0", Exception);
        end
        pchigh = 1'b0;
        opcode = 6'h2b;
        funct = 6'h01;
        #1;
        checks++;
        if (Exception !== 1'b0) begin
            errors++;
            $display("FAIL exc_legal_sw: got E=%b required 0", Exception);
        end
        opcode = 6'h0d;
        #1;
        checks++;
        if (Exception !== 1'b1) begin
            errors++;
            $display("FAIL exc_ori: got E=%b required 1", Exception);
        end
        opcode = 6'h00;
        funct = 6'h2a;
        #1;
        checks++;
        if (Exception !== 1'b0) begin
            errors++;
            $display("FAIL exc_slt: got E=%b required 0", Exception);
        end
        tick();
    endtask

    task automatic test_priority();
        logic [31:0] v;
        wr(A_TCON, 32'h6);
        opcode = 6'h3f;
        #1;
        checks++;
        if (Interrupt !== 1'b1 || Exception !== 1'b0) begin
            errors++;
            $display("FAIL prio: got I=%b E=%b required 1 0",
                     Interrupt, Exception);
        end
        tick();
        opcode = 6'h00;
        pchigh = 1'b1;
        rd(A_CAUSE, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL prio_cause: got %h required 1", v);
        end
        wr(A_TCON, 32'h0);
        pchigh = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] v;
        wr(A_TL, 32'h5);
        wr(A_TCON, 32'h3);
        tick();
        tick();
        rd(A_TL, v);
        checks++;
        if (v !== 32'h7) begin
            errors++;
            $display("FAIL count: got %h required 7", v);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(A_TL, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL rst_tl: got %h required 0", v);
        end
        rd(A_TCON, v);
        checks++;
        if (v !== 32'h0 || Interrupt !== 1'b0) begin
            errors++;
            $display("FAIL rst_tcon: got %h I=%b required 0 0", v, Interrupt);
        end
        opcode = 6'h3f;
        tick();
        opcode = 6'h00;
        wr(A_CAUSE, 32'h1);
        rd(A_CAUSE, v);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL cause_ro: got %h required 2", v);
        end
    endtask

    task automatic test_bus_select();
        logic [31:0] v;
        wr(A_TH, 32'h1234_5678);
        wr(32'h4000_0002, 32'hDEAD_BEEF);
        wr(32'h4000_0010, 32'hDEAD_BEEF);
        rd(A_TH, v);
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL sel_wr: got %h required 12345678", v);
        end
        rd(32'h4000_0001, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL sel_unaligned: got %h required 0", v);
        end
        rd(32'h4000_0010, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL sel_window: got %h required 0", v);
        end
        bus.mem_addr = A_TH;
        bus.mem_rd = 1'b0;
        #1;
        checks++;
        if (bus.mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL sel_nord: got %h required 0", bus.mem_rdata);
        end
    endtask

    initial begin
        bus.mem_addr = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wr = 1'b0;
        bus.mem_rd = 1'b0;
        test_reset();
        test_overflow();
        test_tcon_collision();
        test_exception();
        test_priority();
        test_reset_mid_count();
        test_bus_select();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
